// File: rtl/spr_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spr_cmd_ctrl
// Purpose  : Command controller for a single-port RAM. Accepts one read or
//            write command at a time, returns read data through a
//            valid/ready response port, and can clear the whole RAM with a
//            one-write-per-cycle init sweep.
// Revision : 1.0 - initial release
// ============================================================================
module spr_cmd_ctrl #(
    parameter int                   MEM_WIDTH  = 8,
    parameter int                   ADDR_WIDTH = 8,
    parameter logic [MEM_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_start,
    output logic                  init_done,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [MEM_WIDTH-1:0]  cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [MEM_WIDTH-1:0]  rsp_rdata,
    output logic                  mem_blk_select,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [MEM_WIDTH-1:0]  mem_din,
    input  logic [MEM_WIDTH-1:0]  mem_dout
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_init  = 3'd1;
    localparam logic [2:0] c_write = 3'd2;
    localparam logic [2:0] c_read  = 3'd3;
    localparam logic [2:0] c_resp  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;
    localparam logic [ADDR_WIDTH-1:0] c_addr_one  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [MEM_WIDTH-1:0]  r_wdata;
    logic [MEM_WIDTH-1:0]  r_rdata;
    logic                  r_init_done;
    logic                  w_accept;
    logic                  w_init_go;
    logic                  w_init_last;

    // init_start wins over a command presented in the same IDLE cycle
    assign w_init_go   = (r_state == c_idle) && init_start;
    assign w_accept    = (r_state == c_idle) && !init_start && cmd_valid;
    // The sweep ends on the explicit last address, not on counter wrap
    assign w_init_last = (r_state == c_init) && (r_cnt == c_last_addr);

    // State register; reset aborts any in-flight command, response or sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: begin
                if (init_start) begin
                    w_next = c_init;
                end else if (cmd_valid) begin
                    w_next = cmd_we ? c_write : c_read;
                end
            end
            c_init:  w_next = w_init_last ? c_idle : c_init;
            c_write: w_next = c_idle;
            c_read:  w_next = c_resp;
            c_resp:  w_next = rsp_ready ? c_idle : c_resp;
            default: w_next = c_idle;
        endcase
    end

    // Command capture, sweep counter, read-data register and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= w_init_last;
            if (w_init_go) begin
                r_cnt <= '0;
            end else if (r_state == c_init) begin
                r_cnt <= r_cnt + c_addr_one;
            end
            if (w_accept) begin
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
            end
            if (r_state == c_read) begin
                r_rdata <= mem_dout;
            end
        end
    end

    // Output decode from the state register; cmd_ready alone looks at init_start
    always_comb begin
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        mem_blk_select = 1'b0;
        mem_wr_en      = 1'b0;
        mem_rd_en      = 1'b0;
        mem_address    = r_addr;
        mem_din        = r_wdata;
        case (r_state)
            c_idle: begin
                cmd_ready = !init_start;
            end
            c_init: begin
                mem_blk_select = 1'b1;
                mem_wr_en      = 1'b1;
                mem_address    = r_cnt;
                mem_din        = INIT_VALUE;
            end
            c_write: begin
                mem_blk_select = 1'b1;
                mem_wr_en      = 1'b1;
            end
            c_read: begin
                mem_blk_select = 1'b1;
                mem_rd_en      = 1'b1;
            end
            c_resp: begin
                rsp_valid = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    assign rsp_rdata = r_rdata;
    assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_spr_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spr_cmd_ctrl
// Purpose  : Self-checking scoreboard bench for spr_cmd_ctrl with a RAM model
// Revision : 1.0 - initial release
// ============================================================================
module tb_spr_cmd_ctrl;

    localparam logic [7:0] IV = 8'h3C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init_start = 1'b0;
    logic       init_done;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_we = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_rdata;
    logic       mem_blk_select;
    logic       mem_wr_en;
    logic       mem_rd_en;
    logic [7:0] mem_address;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    spr_cmd_ctrl #(
        .MEM_WIDTH (8),
        .ADDR_WIDTH(8),
        .INIT_VALUE(IV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .init_start    (init_start),
        .init_done     (init_done),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_we        (cmd_we),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .mem_blk_select(mem_blk_select),
        .mem_wr_en     (mem_wr_en),
        .mem_rd_en     (mem_rd_en),
        .mem_address   (mem_address),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout)
    );

    always #5 clk = ~clk;

    // Physical RAM attached to the controller
    logic [7:0] ram [256] = '{default: 8'h00};
    assign mem_dout = ram[mem_address];
    always @(posedge clk) if (mem_blk_select && mem_wr_en) ram[mem_address] <= mem_din;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model and scoreboard queues
    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        bit         last;
    } wr_t;
    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] exp_rsp[$];
    logic [7:0] ref_mem [256];
    logic [7:0] saved_mem [256];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares every RAM strobe and response handshake with the queues
    bit         done_due = 1'b0;
    int         last_done_cyc = -1;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    wr_t        mon_e;
    logic [7:0] mon_v;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
            done_due  = 1'b0;
        end else begin
            chk("enable_exclusive",
                {30'd0, mem_wr_en & mem_rd_en, (mem_wr_en | mem_rd_en) & ~mem_blk_select}, 32'd0);
            if (done_due || init_done) begin
                chk("init_done_pulse", {31'd0, init_done}, {31'd0, done_due});
                if (init_done) last_done_cyc = cyc;
            end
            done_due = 1'b0;
            if (mem_blk_select && mem_wr_en) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_wr.pop_front();
                    chk("wr_addr", {24'd0, mem_address}, {24'd0, mon_e.a});
                    chk("wr_data", {24'd0, mem_din}, {24'd0, mon_e.d});
                    if (mon_e.last) done_due = 1'b1;
                end
            end
            if (mem_blk_select && mem_rd_en) begin
                if (exp_rd.size() == 0) begin
                    chk("unexpected_read", 32'd1, 32'd0);
                end else begin
                    mon_v = exp_rd.pop_front();
                    chk("rd_addr", {24'd0, mem_address}, {24'd0, mon_v});
                end
            end
            if (prev_hold) begin
                chk("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
                chk("rsp_hold_data", {24'd0, rsp_rdata}, {24'd0, prev_data});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_v = exp_rsp.pop_front();
                    chk("rsp_data", {24'd0, rsp_rdata}, {24'd0, mon_v});
                end
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_data = rsp_rdata;
        end
    end

    // Random response backpressure when enabled
    bit rsp_rand = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rsp_rand) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Issue one command; called at 1 time unit after a rising edge
    task automatic do_cmd(input bit we, input logic [7:0] ad, input logic [7:0] dd,
                          input bit hold, input int budget, output int acc);
        logic rdy;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = ad;
        cmd_wdata = dd;
        acc       = -1;
        if (we) begin
            exp_wr.push_back('{ad, dd, 1'b0});
            ref_mem[ad] = dd;
        end else begin
            exp_rd.push_back(ad);
            exp_rsp.push_back(ref_mem[ad]);
        end
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            init_start = 1'b0;
            if (rdy) begin
                acc = cyc;
                break;
            end
        end
        if (!hold) cmd_valid = 1'b0;
        if (acc < 0) chk("cmd_accept_timeout", 32'd1, 32'd0);
    endtask

    // A full sweep leaves every word equal to IV
    task automatic push_init();
        for (int i = 0; i < 256; i++) begin
            exp_wr.push_back('{8'(i), IV, (i == 255)});
            ref_mem[i] = IV;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int acc;
    int prev_acc;
    int t0;
    int t1;
    bit found;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        // Reset state
        #12;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_mem_ctrl", {29'd0, mem_blk_select, mem_wr_en, mem_rd_en}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_address}, 32'd0);
        chk("rst_mem_din", {24'd0, mem_din}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Write 0x12/0xA5 then read it back
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        do_cmd(1'b1, 8'h12, 8'hA5, 1'b0, 10, acc);
        @(negedge clk);
        chk("wr_strobe", {30'd0, mem_blk_select, mem_wr_en}, 32'd3);
        chk("wr_strobe_addr", {24'd0, mem_address}, 32'h12);
        chk("wr_strobe_din", {24'd0, mem_din}, 32'hA5);
        @(negedge clk);
        chk("wr_single_cycle", {31'd0, mem_wr_en}, 32'd0);
        chk("idle_after_wr", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        do_cmd(1'b0, 8'h12, 8'h00, 1'b0, 10, acc);
        @(negedge clk);
        chk("rd_cycle1_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rd_cycle1_rd_en", {31'd0, mem_rd_en}, 32'd1);
        @(negedge clk);
        chk("rd_cycle2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rd_cycle2_data", {24'd0, rsp_rdata}, 32'hA5);
        @(negedge clk);
        chk("rd_released", {31'd0, rsp_valid}, 32'd0);

        // Response backpressure for 5 cycles; init_start during RESP is ignored
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        do_cmd(1'b0, 8'h12, 8'h00, 1'b0, 10, acc);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_data", {24'd0, rsp_rdata}, 32'hA5);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("bp_no_strobe", {31'd0, mem_blk_select}, 32'd0);
            if (k == 1) init_start = 1'b1;
            if (k == 2) init_start = 1'b0;
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_last_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        chk("bp_released", {31'd0, rsp_valid}, 32'd0);
        chk("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);

        // Back-to-back writes with cmd_valid held high
        @(posedge clk);
        #1;
        prev_acc = 0;
        for (int j = 0; j < 4; j++) begin
            do_cmd(1'b1, 8'h20 + 8'(j), 8'h50 + 8'(j), (j < 3), 10, acc);
            if (j > 0) chk("b2b_period", 32'(acc - prev_acc), 32'd2);
            prev_acc = acc;
        end
        repeat (2) @(negedge clk);

        // Full init sweep, then read back 0x7F
        @(posedge clk);
        #1;
        push_init();
        init_start = 1'b1;
        @(negedge clk);
        chk("init_blocks_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1 init_start = 1'b0;
        t0 = cyc;
        t1 = 0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (init_done) begin
                t1 = cyc;
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("init_done_timeout", 32'd1, 32'd0);
        chk("init_length", 32'(t1 - t0), 32'd256);
        chk("init_done_idle", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        chk("init_done_single", {31'd0, init_done}, 32'd0);
        @(posedge clk);
        #1;
        do_cmd(1'b0, 8'h7F, 8'h00, 1'b0, 10, acc);
        repeat (2) @(negedge clk);
        chk("init_readback", {24'd0, rsp_rdata}, {24'd0, IV});
        @(negedge clk);

        // init_start and cmd_valid together: sweep first, then the command
        @(posedge clk);
        #1;
        push_init();
        init_start = 1'b1;
        do_cmd(1'b1, 8'h33, 8'h77, 1'b0, 400, acc);
        chk("cmd_after_init", 32'(acc), 32'(last_done_cyc + 1));
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a sweep at address 0x40
        @(posedge clk);
        #1;
        saved_mem = ref_mem;
        push_init();
        init_start = 1'b1;
        @(posedge clk);
        #1 init_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (mem_wr_en && mem_address == 8'h40) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("init_addr40_timeout", 32'd1, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_ctrl", {29'd0, mem_blk_select, mem_wr_en, mem_rd_en}, 32'd0);
        chk("arst_init_done", {31'd0, init_done}, 32'd0);
        exp_wr.delete();
        exp_rd.delete();
        exp_rsp.delete();
        ref_mem = saved_mem;
        for (int i = 0; i < 64; i++) ref_mem[i] = IV;
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("arst_no_done", {31'd0, init_done}, 32'd0);
        end

        // Randomized traffic against the reference memory
        @(posedge clk);
        #1 rsp_rand = 1'b1;
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            do_cmd(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255))
                                               : (8'h38 + 8'($urandom_range(0, 15))),
                   8'($urandom_range(0, 255)), 1'b0, 50, acc);
        end
        rsp_rand = 1'b0;
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("queues_drained", 32'(exp_wr.size() + exp_rd.size() + exp_rsp.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
